// File: rtl/piano_tiles_pkg.sv
// Shared types and constants for the PianoTiles key input path.
package piano_tiles_pkg;

  localparam int unsigned NUM_KEYS            = 4;
  localparam int unsigned LANE_W              = 2;
  localparam int unsigned DEBOUNCE_CYCLES_50M = 500000;
  localparam int unsigned FIFO_DEPTH          = 2;

  typedef logic [LANE_W-1:0] lane_t;

  typedef struct packed {
    lane_t lane;
    logic  multi;
    logic  is_release;
  } key_evt_t;

  // Highest changed key gives the lane; more than one changed key flags multi.
  function automatic key_evt_t encode_keys(input logic [NUM_KEYS-1:0] edges,
                                           input logic                is_rel);
    key_evt_t    e;
    int unsigned n;
    e = '0;
    n = 0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (edges[i]) begin
        e.lane = LANE_W'(i);
        n++;
      end
    end
    e.multi      = (n > 1);
    e.is_release = is_rel;
    return e;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus saturating stability counter for one active-low key.
// deb is 1 while released, 0 while pressed.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic deb
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      deb   <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_press_capture.sv
// Debounced key events queued in a 2-entry FIFO with valid/ready, plus any_down/start_pulse.
// Optional feature: define KEY_RELEASE_EVT_EN to also queue release events.
module key_press_capture
  import piano_tiles_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
  parameter int unsigned CNT_W           = 19
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic                press_ready,
  output logic                press_valid,
  output lane_t               press_lane,
  output logic                press_multi,
  output logic                press_release,
  output logic                any_down,
  output logic                start_pulse,
  output logic                overflow
);

  logic [NUM_KEYS-1:0] deb;
  logic [NUM_KEYS-1:0] deb_q;
  logic [NUM_KEYS-1:0] fall_c;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clock(clock),
      .reset(reset),
      .key_n(key_n[g]),
      .deb  (deb[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) deb_q <= '1;
    else       deb_q <= deb;
  end

  assign fall_c = deb_q & ~deb;

  key_evt_t evt_c;
  logic     evt_vld_c;
  logic     lost_c;

`ifdef KEY_RELEASE_EVT_EN
  logic [NUM_KEYS-1:0] rise_c;
  key_evt_t            pend_q;
  key_evt_t            pend_d;
  logic                pend_vld_q;
  logic                pend_vld_d;

  assign rise_c = ~deb_q & deb;

  // A release coinciding with a press waits one cycle behind it.
  always_comb begin
    evt_c      = '0;
    evt_vld_c  = 1'b0;
    pend_d     = pend_q;
    pend_vld_d = 1'b0;
    lost_c     = 1'b0;
    if (pend_vld_q) begin
      evt_c     = pend_q;
      evt_vld_c = 1'b1;
      lost_c    = (|fall_c) | (|rise_c);
    end else if (|fall_c) begin
      evt_c     = encode_keys(fall_c, 1'b0);
      evt_vld_c = 1'b1;
      if (|rise_c) begin
        pend_d     = encode_keys(rise_c, 1'b1);
        pend_vld_d = 1'b1;
      end
    end else if (|rise_c) begin
      evt_c     = encode_keys(rise_c, 1'b1);
      evt_vld_c = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end
`else
  always_comb begin
    evt_c     = encode_keys(fall_c, 1'b0);
    evt_vld_c = |fall_c;
  end
  assign lost_c = 1'b0;
`endif

  // FIFO kept as head/tail registers so the outputs come straight from flops.
  key_evt_t head_q, tail_q, head_d, tail_d;
  logic     head_vld_q, tail_vld_q, head_vld_d, tail_vld_d;
  logic     pop_c;
  logic     drop_c;

  assign pop_c = head_vld_q & press_ready;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    drop_c     = 1'b0;
    if (pop_c) begin
      head_d     = tail_q;
      head_vld_d = tail_vld_q;
      tail_vld_d = 1'b0;
    end
    if (evt_vld_c) begin
      if (!head_vld_d) begin
        head_d     = evt_c;
        head_vld_d = 1'b1;
      end else if (!tail_vld_d) begin
        tail_d     = evt_c;
        tail_vld_d = 1'b1;
      end else begin
        drop_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      head_vld_q  <= 1'b0;
      tail_vld_q  <= 1'b0;
      overflow    <= 1'b0;
      any_down    <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      head_vld_q  <= head_vld_d;
      tail_vld_q  <= tail_vld_d;
      overflow    <= overflow | drop_c | lost_c;
      any_down    <= ~&deb;
      start_pulse <= ~&deb & ~any_down;
    end
  end

  assign press_valid   = head_vld_q;
  assign press_lane    = head_q.lane;
  assign press_multi   = head_q.multi;
  assign press_release = head_q.is_release;

endmodule
